// File: rtl/led_scan.sv
// led_scan: time-multiplexed hex display scanner feeding a shared 7-segment
// decoder. Each digit owns a slot of DWELL clocks. The first BLANK clocks of
// a slot are dark to avoid ghosting. The displayed value is double-buffered
// and changes only at frame boundaries. Optional leading-zero blanking hides
// high-order zero digits; digit 0 is never hidden.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   load   in   strobe: capture value into the pending buffer
//   value  in   4*DIGITS hex digits, nibble i = digit i (digit 0 = LSD)
//   lzb    in   leading-zero blanking enable, latched at frame boundary
//   D      out  nibble for the decoder
//   en     out  decoder enable
//   dig    out  one-hot digit select, active-high
//   frame  out  one-cycle pulse on the last cycle of each frame
//
// The outputs are registers. They are loaded with the decode of the *next*
// scan state, so each output matches the scan state of the same cycle.
module led_scan #(
   parameter int DIGITS = 4,
   parameter int DWELL  = 1000,
   parameter int BLANK  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  lzb,
   output logic [3:0]            D,
   output logic                  en,
   output logic [DIGITS-1:0]     dig,
   output logic                  frame
);

   localparam int VW = 4 * DIGITS;
   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
   localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

   logic [CW-1:0] cnt_r,     cnt_n_s;
   logic [IW-1:0] idx_r,     idx_n_s;
   logic [VW-1:0] active_r,  active_n_s;
   logic [VW-1:0] pending_r, pending_n_s;
   logic          pend_v_r,  pend_v_n_s;
   logic          lzb_q_r,   lzb_q_n_s;
   logic          cnt_wrap_s, boundary_s;
   logic          phase_show_s, suppress_s, show_s;
   logic [3:0]          d_n_s;
   logic [DIGITS-1:0]   dig_n_s;
   logic                frame_n_s;

   // Select nibble i of v.
   function automatic logic [3:0] nibble_at(input logic [VW-1:0] v,
                                            input logic [IW-1:0] i);
      logic [3:0] n;
      n = 4'h0;
      for (int k = 0; k < DIGITS; k++) begin
         n = (IW'(k) == i) ? v[4*k +: 4] : n;
      end
      return n;
   endfunction

   // True when nibbles i..DIGITS-1 of v are all zero.
   function automatic logic upper_zero(input logic [VW-1:0] v,
                                       input logic [IW-1:0] i);
      logic z;
      z = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         z = ((IW'(k) >= i) && (v[4*k +: 4] != 4'h0)) ? 1'b0 : z;
      end
      return z;
   endfunction

   // Next scan position, buffer transfers and latched blanking mode.
   always_comb begin
      cnt_n_s     = cnt_r;
      idx_n_s     = idx_r;
      active_n_s  = active_r;
      pending_n_s = pending_r;
      pend_v_n_s  = pend_v_r;
      lzb_q_n_s   = lzb_q_r;
      cnt_wrap_s  = (cnt_r == CNT_MAX);
      boundary_s  = cnt_wrap_s && (idx_r == IDX_MAX);

      if (cnt_wrap_s) begin
         cnt_n_s = {CW{1'b0}};
         if (idx_r == IDX_MAX) begin
            idx_n_s = {IW{1'b0}};
         end else begin
            idx_n_s = idx_r + IW'(1);
         end
      end else begin
         cnt_n_s = cnt_r + CW'(1);
      end

      // A load on the boundary cycle bypasses the pending buffer.
      if (boundary_s) begin
         if (load) begin
            active_n_s = value;
         end else if (pend_v_r) begin
            active_n_s = pending_r;
         end else begin
            active_n_s = active_r;
         end
         pend_v_n_s = 1'b0;
         lzb_q_n_s  = lzb;
      end else if (load) begin
         pending_n_s = value;
         pend_v_n_s  = 1'b1;
      end else begin
         pending_n_s = pending_r;
      end
   end

   // With no blanking gap the SHOW phase covers the whole slot.
   generate
      if (BLANK == 0) begin : g_no_blank
         assign phase_show_s = 1'b1;
      end else begin : g_blank
         assign phase_show_s = (cnt_n_s >= BLANK_C);
      end
   endgenerate

   // Decode of the next scan state into the output values.
   always_comb begin
      d_n_s      = nibble_at(active_n_s, idx_n_s);
      suppress_s = lzb_q_n_s && (idx_n_s != {IW{1'b0}}) &&
                   upper_zero(active_n_s, idx_n_s);
      show_s     = phase_show_s && !suppress_s;
      frame_n_s  = (cnt_n_s == CNT_MAX) && (idx_n_s == IDX_MAX);
      dig_n_s    = {DIGITS{1'b0}};
      for (int k = 0; k < DIGITS; k++) begin
         dig_n_s[k] = show_s && (IW'(k) == idx_n_s);
      end
   end

   // Scan state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r     <= {CW{1'b0}};
         idx_r     <= {IW{1'b0}};
         active_r  <= {VW{1'b0}};
         pending_r <= {VW{1'b0}};
         pend_v_r  <= 1'b0;
         lzb_q_r   <= 1'b0;
      end else begin
         cnt_r     <= cnt_n_s;
         idx_r     <= idx_n_s;
         active_r  <= active_n_s;
         pending_r <= pending_n_s;
         pend_v_r  <= pend_v_n_s;
         lzb_q_r   <= lzb_q_n_s;
      end
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         D     <= 4'h0;
         en    <= 1'b0;
         dig   <= {DIGITS{1'b0}};
         frame <= 1'b0;
      end else begin
         D     <= d_n_s;
         en    <= show_s;
         dig   <= dig_n_s;
         frame <= frame_n_s;
      end
   end

endmodule

// File: tb/tb_led_scan.sv
// Bench for led_scan with DIGITS=4, DWELL=10, BLANK=2. A reference model
// tracks elapsed cycles since reset release and derives digit/phase with
// division and modulo; buffer transfers follow the load/frame rules.
module tb_led_scan;

   localparam int DIGITS = 4;
   localparam int DWELL  = 10;
   localparam int BLANK  = 2;
   localparam int FR     = DIGITS * DWELL;

   logic        clk;
   logic        reset;
   logic        load;
   logic [15:0] value;
   logic        lzb;
   logic [3:0]  D;
   logic        en;
   logic [3:0]  dig;
   logic        frame;

   led_scan #(.DIGITS(DIGITS), .DWELL(DWELL), .BLANK(BLANK)) dut (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .value (value),
      .lzb   (lzb),
      .D     (D),
      .en    (en),
      .dig   (dig),
      .frame (frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          m_t;
   logic [15:0] m_active;
   logic [15:0] m_pending;
   logic        m_pend_v;
   logic        m_lzb_q;
   logic        lz_v;
   logic        forbid_nine;

   task automatic check_cycle();
      int          pos, d, c;
      logic [15:0] sh;
      logic [3:0]  one, e_d, e_dig;
      logic        supp, e_en, e_frame;
      pos     = m_t % FR;
      d       = pos / DWELL;
      c       = pos % DWELL;
      sh      = m_active >> (4 * d);
      e_d     = sh[3:0];
      supp    = m_lzb_q && (d != 0) && (sh == 16'h0000);
      e_en    = (c >= BLANK) && !supp;
      one     = 4'b0001;
      e_dig   = e_en ? (one << d) : 4'b0000;
      e_frame = (pos == FR - 1);
      n_checks++;
      assert (D === e_d) else begin
         n_fail++;
         $error("FAIL D t=%0d got=%h exp=%h", m_t, D, e_d);
      end
      n_checks++;
      assert (en === e_en) else begin
         n_fail++;
         $error("FAIL en t=%0d got=%b exp=%b", m_t, en, e_en);
      end
      n_checks++;
      assert (dig === e_dig) else begin
         n_fail++;
         $error("FAIL dig t=%0d got=%b exp=%b", m_t, dig, e_dig);
      end
      n_checks++;
      assert (frame === e_frame) else begin
         n_fail++;
         $error("FAIL frame t=%0d got=%b exp=%b", m_t, frame, e_frame);
      end
      if (forbid_nine) begin
         n_checks++;
         assert (D !== 4'h9) else begin
            n_fail++;
            $error("FAIL discarded t=%0d got=%h exp=not 9", m_t, D);
         end
      end
   endtask

   task automatic model_edge();
      if (reset) begin
         m_t       = 0;
         m_active  = 16'h0000;
         m_pending = 16'h0000;
         m_pend_v  = 1'b0;
         m_lzb_q   = 1'b0;
      end else begin
         if ((m_t % FR) == FR - 1) begin
            m_active = load ? value : (m_pend_v ? m_pending : m_active);
            m_pend_v = 1'b0;
            m_lzb_q  = lzb;
         end else if (load) begin
            m_pending = value;
            m_pend_v  = 1'b1;
         end
         m_t++;
      end
   endtask

   // Check the current cycle, then drive inputs for the coming edge.
   task automatic cyc(input logic rst, input logic ld, input logic [15:0] val);
      @(negedge clk);
      check_cycle();
      reset = rst;
      load  = ld;
      value = val;
      lzb   = lz_v;
      @(posedge clk);
      model_edge();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0000);
   endtask

   task automatic run_to(input int p);
      for (int i = 0; (i < FR) && ((m_t % FR) != p); i++) idle(1);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 16'h0000);
   endtask

   initial begin
      logic [15:0] rv;
      reset = 1'b1; load = 1'b0; value = 16'h0000; lzb = 1'b0;
      lz_v = 1'b0; forbid_nine = 1'b0;
      @(posedge clk);
      model_edge();

      // Reset and idle scan over two frames.
      do_reset(3);
      idle(2 * FR);

      // Double buffering: load mid-frame, visible from next frame.
      do_reset(1);
      idle(15);
      cyc(1'b0, 1'b1, 16'h1234);
      idle(24 + 2 * FR);

      // Leading-zero blanking.
      lz_v = 1'b1;
      run_to(5);
      cyc(1'b0, 1'b1, 16'h0005);
      idle(2 * FR);
      cyc(1'b0, 1'b1, 16'h0000);
      idle(2 * FR);
      cyc(1'b0, 1'b1, 16'h0105);
      idle(2 * FR);
      lz_v = 1'b0;

      // Load on the frame cycle overrides a pending value.
      run_to(10);
      cyc(1'b0, 1'b1, 16'h1111);
      run_to(FR - 1);
      cyc(1'b0, 1'b1, 16'hABCD);
      idle(FR);
      // Last load in a frame wins.
      run_to(3);
      cyc(1'b0, 1'b1, 16'h1111);
      idle(7);
      cyc(1'b0, 1'b1, 16'h2222);
      idle(2 * FR);

      // Mid-frame reset discards the pending value.
      run_to(3);
      cyc(1'b0, 1'b1, 16'h9999);
      run_to(25);
      cyc(1'b1, 1'b0, 16'h0000);
      forbid_nine = 1'b1;
      idle(2 * FR);
      forbid_nine = 1'b0;

      // Randomized loads, values, blanking mode and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < 4; k++) begin
            rv[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         end
         if ($urandom_range(0, 49) == 0) lz_v = ~lz_v;
         cyc(($urandom_range(0, 399) == 0), ($urandom_range(0, 15) == 0), rv);
      end
      idle(FR);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout reached got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
